act_layer: RTL

Parametrised activation layer for the CNN datapath. Captures one full feature-map word (CH×PIX signed fixed-point elements) on `load`, then applies a runtime-selected activation (pass / ReLU / ELU / leaky ReLU). It processes LANES elements per cycle through a registered activation unit and holds the result with `valid` until `load` drops. It sits between a convolution layer's output register and the next layer's `load`/`d` inputs, replacing fixed-function per-layer ELU blocks.

---
 rtl/act_pkg.sv | 17 +
 rtl/act_unit.sv | 32 +++
 rtl/act_layer.sv | 70 +++++++
 3 files changed

// File: rtl/act_pkg.sv
// act_pkg: shared constants, mode/state encodings and the ELU lookup table for act_layer.
package act_pkg;
  localparam int FRAC_LEN = 10;
  typedef enum logic [1:0] {MODE_PASS = 2'b00, MODE_RELU = 2'b01, MODE_ELU = 2'b10, MODE_LEAKY = 2'b11} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // round((exp(-i/8) - 1) * 2^FRAC_LEN), i = 0..63
  localparam int ELU_LUT [64] = '{
       0,  -120,  -227,  -320,  -403,  -476,  -540,  -597,
    -647,  -692,  -731,  -765,  -796,  -822,  -846,  -867,
    -885,  -902,  -916,  -929,  -940,  -950,  -959,  -966,
    -973,  -979,  -984,  -989,  -993,  -997, -1000, -1003,
   -1005, -1007, -1009, -1011, -1013, -1014, -1015, -1016,
   -1017, -1018, -1019, -1019, -1020, -1020, -1021, -1021,
   -1021, -1022, -1022, -1022, -1022, -1023, -1023, -1023,
   -1023, -1023, -1023, -1023, -1023, -1024, -1024, -1024
  };
endpackage

// File: rtl/act_unit.sv
// act_unit: one-element registered activation (pass/ReLU/ELU/leaky).
// ACT_LEAKY_EN enables leaky ReLU on mode 11; otherwise mode 11 acts as ReLU.
module act_unit
  import act_pkg::*;
#(
  parameter int DATA_LEN = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_LEN-1:0] x,
  input  mode_t                      mode,
  output logic signed [DATA_LEN-1:0] y
);
  logic signed [DATA_LEN:0] m;
  logic [DATA_LEN:0] idx;
  logic signed [DATA_LEN-1:0] elu, leaky, y_n;
  // one guard bit keeps the negation of the most negative input from overflowing
  assign m = -{x[DATA_LEN-1], x};
  assign idx = m >> 7;
  assign elu = idx > (DATA_LEN+1)'(63) ? DATA_LEN'(-(1 << FRAC_LEN)) : DATA_LEN'(ELU_LUT[idx[5:0]]);
`ifdef ACT_LEAKY_EN
  assign leaky = x >>> 3;
`else
  assign leaky = '0;
`endif
  assign y_n = (!x[DATA_LEN-1] || mode == MODE_PASS) ? x :
               mode == MODE_ELU   ? elu   :
               mode == MODE_LEAKY ? leaky : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) y <= '0;
    else        y <= y_n;
endmodule

// File: rtl/act_layer.sv
// act_layer: captures a CH*PIX feature-map word and applies the selected activation LANES elements per cycle.
// ACT_LEAKY_EN (in act_unit) enables leaky ReLU on mode 11.
module act_layer
  import act_pkg::*;
#(
  parameter int DATA_LEN = 18,
  parameter int CH       = 32,
  parameter int PIX      = 12,
  parameter int LANES    = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [1:0]                   mode,
  input  logic [CH*PIX*DATA_LEN-1:0]   d,
  output logic                         valid,
  output logic [CH*PIX*DATA_LEN-1:0]   q
);
  localparam int N = CH * PIX;
  localparam int BEATS = N / LANES;
  localparam int CW = $clog2(BEATS + 1);
  state_t st;
  mode_t mode_r;
  logic [N*DATA_LEN-1:0] din;
  logic [CW-1:0] cnt, wb, sel;
  logic pend;
  logic signed [DATA_LEN-1:0] x [LANES];
  logic signed [DATA_LEN-1:0] y [LANES];
  assign sel = cnt < CW'(BEATS) ? cnt : '0;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign x[l] = din[(int'(sel)*LANES + l)*DATA_LEN +: DATA_LEN];
    act_unit #(.DATA_LEN(DATA_LEN)) u_act (.clk(clk), .rst_n(rst_n), .x(x[l]), .mode(mode_r), .y(y[l]));
  end
  // pend/wb trail cnt by one cycle to match the act_unit register stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st     <= IDLE;
      mode_r <= MODE_PASS;
      din    <= '0;
      cnt    <= '0;
      wb     <= '0;
      pend   <= 1'b0;
      valid  <= 1'b0;
      q      <= '0;
    end else begin
      case (st)
        IDLE: if (load) begin
          din    <= d;
          mode_r <= mode_t'(mode);
          cnt    <= '0;
          st     <= RUN;
        end
        RUN: begin
          pend <= cnt < CW'(BEATS);
          wb   <= cnt;
          if (cnt < CW'(BEATS)) cnt <= cnt + 1'b1;
          if (pend) for (int l = 0; l < LANES; l++) q[(int'(wb)*LANES + l)*DATA_LEN +: DATA_LEN] <= y[l];
          if (pend && wb == CW'(BEATS - 1)) begin
            st    <= DONE;
            valid <= 1'b1;
          end
        end
        DONE: if (!load) begin
          st    <= IDLE;
          valid <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
endmodule
